// File: rtl/wb_rr_arbiter.sv
//==============================================================================
// Module      : wb_rr_arbiter
// Description : Round-robin Wishbone B3 arbiter. Shares one slave port among
//               NUM_MASTERS masters; ownership is held for a whole bus cycle
//               (cyc), so classic and incrementing bursts are never split.
//               Optional watchdog (macro WB_RR_ARB_WATCHDOG_EN) aborts a
//               stalled transfer by returning err to the owner.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    // master side (master 0 in the LSB slice)
    input  logic [AW*NUM_MASTERS-1:0]     wbm_adr_i,
    input  logic [DW*NUM_MASTERS-1:0]     wbm_dat_i,
    input  logic [DW/8*NUM_MASTERS-1:0]   wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]        wbm_we_i,
    input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
    input  logic [3*NUM_MASTERS-1:0]      wbm_cti_i,
    input  logic [2*NUM_MASTERS-1:0]      wbm_bte_i,
    output logic [DW*NUM_MASTERS-1:0]     wbm_dat_o,
    output logic [NUM_MASTERS-1:0]        wbm_ack_o,
    output logic [NUM_MASTERS-1:0]        wbm_err_o,
    output logic [NUM_MASTERS-1:0]        wbm_rty_o,
    // slave side
    output logic [AW-1:0]                 wbs_adr_o,
    output logic [DW-1:0]                 wbs_dat_o,
    output logic [DW/8-1:0]               wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    output logic [2:0]                    wbs_cti_o,
    output logic [1:0]                    wbs_bte_o,
    input  logic [DW-1:0]                 wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    input  logic                          wbs_rty_i,
    // status
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic                          timeout_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [IW-1:0]            r_last;
    logic [IW-1:0]            r_owner;

    logic [2*NUM_MASTERS-1:0] w_req2;
    logic [IW-1:0]            w_winner;
    logic                     w_found;
    int                       w_sum;

    logic                     w_owner_cyc;
    logic                     w_owner_stb;
    logic                     w_abort;
    logic                     w_route;
    logic                     w_rsp_ok;
    logic                     w_unused;

    // Pick the first requester after the last owner: rotate the request
    // vector so position 0 corresponds to last+1, then scan upwards.
    always_comb begin
        w_req2   = {wbm_cyc_i, wbm_cyc_i} >> (int'(r_last) + 1);
        w_winner = r_last;
        w_found  = 1'b0;
        w_sum    = 0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!w_found && w_req2[j]) begin
                w_found = 1'b1;
                w_sum   = int'(r_last) + 1 + j;
                if (w_sum >= NUM_MASTERS) begin
                    w_sum = w_sum - NUM_MASTERS;
                end
                w_winner = IW'(w_sum);
            end
        end
    end

    assign w_owner_cyc = wbm_cyc_i[r_owner];
    assign w_owner_stb = wbm_stb_i[r_owner];

`ifdef WB_RR_ARB_WATCHDOG_EN
    logic [15:0] r_wd_cnt;

    // Watchdog: counts strobed cycles without any slave response; it is
    // zero whenever the arbiter is idle, hence zero at every new grant.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wd_cnt <= 16'd0;
        end else if (r_state == ST_IDLE) begin
            r_wd_cnt <= 16'd0;
        end else if (wbs_ack_i || wbs_err_i || wbs_rty_i) begin
            r_wd_cnt <= 16'd0;
        end else if (wbs_stb_o) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    assign w_abort = (r_state == ST_OWN) && (r_wd_cnt == c_timeout);
`else
    assign w_abort = 1'b0;
`endif

    // The bus is routed only while owned and not in the abort cycle.
    assign w_route  = (r_state == ST_OWN) && !w_abort;
    assign w_rsp_ok = w_route && w_owner_cyc;

    // Ownership state machine: grant, round-robin pointer and owner index.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_owner <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|wbm_cyc_i) begin
                        r_state <= ST_OWN;
                        r_grant <= NUM_MASTERS'(1) << w_winner;
                        r_last  <= w_winner;
                        r_owner <= w_winner;
                    end
                end
                ST_OWN: begin
                    if (!w_owner_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end else if (w_abort) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_owner_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Owner-to-slave request path; cyc/stb follow the owner's cyc in the
    // same cycle so a releasing master never leaves a phantom strobe.
    always_comb begin
        wbs_cyc_o = w_route && w_owner_cyc;
        wbs_stb_o = w_route && w_owner_cyc && w_owner_stb;
        wbs_we_o  = w_route && wbm_we_i[r_owner];
        wbs_adr_o = w_route ? wbm_adr_i[r_owner*AW +: AW] : '0;
        wbs_dat_o = w_route ? wbm_dat_i[r_owner*DW +: DW] : '0;
        wbs_sel_o = w_route ? wbm_sel_i[r_owner*SW +: SW] : '0;
        wbs_cti_o = w_route ? wbm_cti_i[r_owner*3 +: 3]   : 3'b000;
        wbs_bte_o = w_route ? wbm_bte_i[r_owner*2 +: 2]   : 2'b00;
    end

    // Slave-to-owner response path; the abort cycle replaces any slave
    // response with err so a late ack is discarded.
    always_comb begin
        wbm_ack_o = (w_rsp_ok && wbs_ack_i) ? r_grant : '0;
        wbm_rty_o = (w_rsp_ok && wbs_rty_i) ? r_grant : '0;
        wbm_err_o = ((w_rsp_ok && wbs_err_i) || w_abort) ? r_grant : '0;
    end

    // Read data is shared by all masters; only the owner sees an ack.
    generate
        for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_rdata
            assign wbm_dat_o[g*DW +: DW] = wbs_dat_i;
        end
    endgenerate

    assign grant_o   = r_grant;
    assign timeout_o = w_abort;

    // Upper half of the rotated request vector is only scan scaffolding.
    assign w_unused = ^{c_timeout, w_req2[2*NUM_MASTERS-1:NUM_MASTERS]};

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
//==============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Directed self-checking bench for wb_rr_arbiter (3 masters).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk;
    logic              rst_n;
    logic [AW*N-1:0]   m_adr;
    logic [DW*N-1:0]   m_dat;
    logic [SW*N-1:0]   m_sel;
    logic [N-1:0]      m_we, m_cyc, m_stb;
    logic [3*N-1:0]    m_cti;
    logic [2*N-1:0]    m_bte;
    logic [DW*N-1:0]   m_dat_o;
    logic [N-1:0]      m_ack, m_err, m_rty;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel;
    logic              s_we, s_cyc, s_stb;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack, s_err, s_rty;
    logic [N-1:0]      grant;
    logic              tmo;

    int nv = 0;
    int ne = 0;

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk_i (clk),     .wb_rst_ni(rst_n),
        .wbm_adr_i(m_adr),   .wbm_dat_i(m_dat),   .wbm_sel_i(m_sel),
        .wbm_we_i (m_we),    .wbm_cyc_i(m_cyc),   .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti),   .wbm_bte_i(m_bte),   .wbm_dat_o(m_dat_o),
        .wbm_ack_o(m_ack),   .wbm_err_o(m_err),   .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr),   .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel),
        .wbs_we_o (s_we),    .wbs_cyc_o(s_cyc),   .wbs_stb_o(s_stb),
        .wbs_cti_o(s_cti),   .wbs_bte_o(s_bte),   .wbs_dat_i(s_dat_i),
        .wbs_ack_i(s_ack),   .wbs_err_i(s_err),   .wbs_rty_i(s_rty),
        .grant_o  (grant),   .timeout_o(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_m(input int m, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[m]          = cyc;
        m_stb[m]          = stb;
        m_we[m]           = 1'b0;
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = 32'h0;
        m_sel[m*SW +: SW] = 4'hF;
        m_cti[m*3 +: 3]   = cti;
        m_bte[m*2 +: 2]   = 2'b00;
    endtask

    task automatic clear_inputs();
        for (int m = 0; m < N; m++) set_m(m, 1'b0, 1'b0, 32'h0, 3'b000);
        s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        set_m(1, 1'b1, 1'b1, 32'h10, 3'b000);
        s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;
        @(negedge clk); @(negedge clk);
        nv++; if (grant !== 3'b000) begin ne++; $display("FAIL rst_grant: got %b want 000", grant); end
        nv++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin ne++; $display("FAIL rst_ctl: got %b want 000", {s_cyc, s_stb, s_we}); end
        nv++; if (s_adr !== 32'h0) begin ne++; $display("FAIL rst_adr: got %h want 0", s_adr); end
        nv++; if ({m_ack, m_err, m_rty} !== 9'h0) begin ne++; $display("FAIL rst_rsp: got %b want 0", {m_ack, m_err, m_rty}); end
        nv++; if (tmo !== 1'b0) begin ne++; $display("FAIL rst_tmo: got %b want 0", tmo); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick(); set_m(1, 1'b1, 1'b1, 32'h10, 3'b000);
        @(negedge clk);
        nv++; if ({grant, s_cyc} !== 4'b0000) begin ne++; $display("FAIL single_lat: got %b want 0000", {grant, s_cyc}); end
        tick();
        @(negedge clk);
        nv++; if (grant !== 3'b010) begin ne++; $display("FAIL single_grant: got %b want 010", grant); end
        nv++; if (s_cyc !== 1'b1 || s_adr !== 32'h10) begin ne++; $display("FAIL single_route: got cyc=%b adr=%h want 1/00000010", s_cyc, s_adr); end
        nv++; if (m_ack !== 3'b000) begin ne++; $display("FAIL single_noack: got %b want 000", m_ack); end
        tick(); s_ack = 1'b1; s_dat_i = 32'hCAFEBABE;
        @(negedge clk);
        nv++; if (m_ack !== 3'b010) begin ne++; $display("FAIL single_ack: got %b want 010", m_ack); end
        nv++; if (m_dat_o[63:32] !== 32'hCAFEBABE) begin ne++; $display("FAIL single_rdata: got %h want cafebabe", m_dat_o[63:32]); end
        tick(); s_ack = 1'b0; set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge clk);
        nv++; if ({s_cyc, s_stb, m_ack} !== 5'b0) begin ne++; $display("FAIL single_release: got %b want 00000", {s_cyc, s_stb, m_ack}); end
        tick();
        @(negedge clk);
        nv++; if (grant !== 3'b000) begin ne++; $display("FAIL single_idle: got %b want 000", grant); end
    endtask

    task automatic test_fairness();
        logic [2:0] g_exp [18];
        logic [2:0] drop;
        g_exp = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                  3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 3'b001,
                  3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100};
        do_reset();
        drop = 3'b000;
        for (int k = 0; k < 18; k++) begin
            tick();
            s_ack = 1'b1;
            for (int m = 0; m < N; m++)
                set_m(m, !drop[m], !drop[m], 32'h200 + 32'(m * 16), 3'b000);
            @(negedge clk);
            nv++; if (grant !== g_exp[k]) begin ne++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, g_exp[k]); end
            nv++; if (m_ack !== ((k % 3 == 1) ? g_exp[k] : 3'b000)) begin ne++; $display("FAIL rr_ack[%0d]: got %b want %b", k, m_ack, (k % 3 == 1) ? g_exp[k] : 3'b000); end
            drop = m_ack;
        end
        tick(); clear_inputs();
        tick();
    endtask

    task automatic test_burst();
        // pointer sits on master 2; master 0 wins alone in IDLE
        tick(); set_m(0, 1'b1, 1'b1, 32'h100, 3'b010);
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            tick();
            s_ack = 1'b1;
            set_m(0, 1'b1, 1'b1, 32'h100 + 32'(b * 4), (b == 3) ? 3'b111 : 3'b010);
            if (b >= 1) set_m(2, 1'b1, 1'b1, 32'h300, 3'b000);
            @(negedge clk);
            nv++; if (grant !== 3'b001 || m_ack !== 3'b001) begin ne++; $display("FAIL burst_beat%0d: got grant=%b ack=%b want 001/001", b, grant, m_ack); end
            nv++; if (s_adr !== 32'h100 + 32'(b * 4) || s_cti !== ((b == 3) ? 3'b111 : 3'b010)) begin ne++; $display("FAIL burst_addr%0d: got adr=%h cti=%b", b, s_adr, s_cti); end
        end
        tick(); s_ack = 1'b0; set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge clk);
        nv++; if (s_cyc !== 1'b0 || grant !== 3'b001) begin ne++; $display("FAIL burst_drop: got cyc=%b grant=%b want 0/001", s_cyc, grant); end
        tick();
        @(negedge clk);
        nv++; if (grant !== 3'b000) begin ne++; $display("FAIL burst_gap: got %b want 000", grant); end
        tick();
        @(negedge clk);
        nv++; if (grant !== 3'b100 || s_adr !== 32'h300) begin ne++; $display("FAIL burst_next: got grant=%b adr=%h want 100/00000300", grant, s_adr); end
    endtask

    task automatic test_isolation();
        // master 2 still owns the bus; master 0 requests meanwhile
        tick(); s_err = 1'b1; set_m(0, 1'b1, 1'b1, 32'h40, 3'b000);
        @(negedge clk);
        nv++; if (m_err !== 3'b100) begin ne++; $display("FAIL iso_err: got %b want 100", m_err); end
        nv++; if ({m_ack, m_rty} !== 6'b0) begin ne++; $display("FAIL iso_ackrty: got %b want 000000", {m_ack, m_rty}); end
        tick(); s_err = 1'b0; s_rty = 1'b1;
        @(negedge clk);
        nv++; if (m_rty !== 3'b100 || m_err !== 3'b000) begin ne++; $display("FAIL iso_rty: got rty=%b err=%b want 100/000", m_rty, m_err); end
        tick(); clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tick(); set_m(0, 1'b1, 1'b1, 32'h500, 3'b010);
        for (int b = 0; b < 3; b++) begin
            tick(); s_ack = 1'b1; set_m(0, 1'b1, 1'b1, 32'h500 + 32'(b * 4), 3'b010);
        end
        #2;
        nv++; if (s_cyc !== 1'b1) begin ne++; $display("FAIL mid_pre: got cyc=%b want 1", s_cyc); end
        rst_n = 1'b0;
        #1;
        nv++; if ({s_cyc, s_stb, grant, m_ack} !== 8'b0) begin ne++; $display("FAIL mid_async: got %b want 0", {s_cyc, s_stb, grant, m_ack}); end
        clear_inputs();
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        tick();
        for (int m = 0; m < N; m++) set_m(m, 1'b1, 1'b1, 32'h600 + 32'(m * 16), 3'b000);
        @(negedge clk);
        nv++; if (grant !== 3'b000) begin ne++; $display("FAIL mid_idle: got %b want 000", grant); end
        tick();
        @(negedge clk);
        nv++; if (grant !== 3'b001 || s_adr !== 32'h600) begin ne++; $display("FAIL mid_winner: got grant=%b adr=%h want 001/00000600", grant, s_adr); end
        tick(); clear_inputs();
        tick();
    endtask

`ifdef WB_RR_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        logic [2:0] gexp;
        logic       cexp;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            tick();
            set_m(0, (k < 11), (k < 11), 32'h700, 3'b000);
            set_m(1, 1'b1, 1'b1, 32'h710, 3'b000);
            @(negedge clk);
            gexp = (k == 0 || k == 12) ? 3'b000 : (k == 13) ? 3'b010 : 3'b001;
            cexp = (k >= 1 && k <= 8) || (k == 13);
            nv++; if (tmo !== (k == 9) || m_err[0] !== (k == 9)) begin ne++; $display("FAIL wd_pulse[%0d]: got tmo=%b err0=%b want %b", k, tmo, m_err[0], (k == 9)); end
            nv++; if (s_cyc !== cexp || grant !== gexp) begin ne++; $display("FAIL wd_bus[%0d]: got cyc=%b grant=%b want %b/%b", k, s_cyc, grant, cexp, gexp); end
        end
        tick(); clear_inputs();
        tick();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_isolation();
        test_reset_mid_burst();
`ifdef WB_RR_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone B3 arbiter that shares the single main-memory slave port between the debug master and the per-core instruction and data bus masters, NUM_MASTERS = 1+2*NUM_CORES. Ownership is granted per bus cycle (cyc), so a granted master keeps the slave through a complete classic or incrementing burst. A watchdog can abort a stalled transfer by returning err to the owner.

## Interface
- NUM_MASTERS, 3: number of requesting masters; master 0 occupies the LSB slice of every flattened bus.
- AW, 32: address width.
- DW, 32: data width; select width is DW/8.
- TIMEOUT, 255: watchdog limit in cycles, 1..65535; used only when the watchdog macro is defined.

Ports, clock and reset first:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- wb_rst_ni  in  1  reset; one clock, asynchronous assertion, active-low.
- wbm_adr_i  in  AW*NUM_MASTERS  master addresses.
- wbm_dat_i  in  DW*NUM_MASTERS  master write data.
- wbm_sel_i  in  DW/8*NUM_MASTERS  byte selects.
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  per-master controls.
- wbm_cti_i  in  3*NUM_MASTERS; wbm_bte_i  in  2*NUM_MASTERS  burst tags.
- wbm_dat_o  out  DW*NUM_MASTERS  read data; wbs_dat_i is broadcast to every slice.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS  per-master responses.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  slave side, widths AW, DW, DW/8, 1, 1, 1, 3, 2.
- wbs_dat_i  in  DW; wbs_ack_i, wbs_err_i, wbs_rty_i  in  1  slave responses.
- grant_o  out  NUM_MASTERS  registered one-hot owner; all zeros when idle.
- timeout_o  out  1  one-cycle pulse on a watchdog abort.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner granted, bus routed.
  - DRAIN: watchdog abort issued; waiting for the owner to drop cyc.
- Reset state:
  - State is IDLE.
  - grant_o = 0 and timeout_o = 0.
  - The round-robin pointer last = NUM_MASTERS-1, so master 0 has top priority after reset.
  - All wbs_* outputs and all wbm_ack/err/rty_o are 0.
- IDLE → OWN: when any wbm_cyc_i is high, the winner is the first requester scanning last+1, last+2, … (mod NUM_MASTERS). grant_o and last are set to the winner on the next edge.
- In OWN:
  - The slave outputs equal the owner's inputs.
  - The owner's ack/err/rty_o equal the slave's ack/err/rty_i.
  - Non-owners see ack/err/rty_o = 0.
- OWN → IDLE: when the owner's wbm_cyc_i is low. wbs_cyc_o and wbs_stb_o are gated to 0 in that same cycle (combinational on the owner's cyc), so no phantom strobe is presented.
- Requests from other masters never preempt the owner, including during cti=010 bursts and between beats.
- In IDLE and DRAIN:
  - wbs_cyc_o = wbs_stb_o = 0.
  - All master responses are 0.
  - Remaining wbs_* outputs are driven to 0.

## Timing
- Arbitration latency: a request in an IDLE cycle is granted at the next edge, so wbs_cyc_o first rises one cycle after wbm_cyc_i.
- Handover: owner drops cyc in cycle N; IDLE in N+1, where the next winner is chosen; new owner is on the bus in N+2. A one-cycle gap is mandatory.
- A single requester re-requesting immediately is regranted after the same one-cycle gap.
- Response path owner-to-slave and slave-to-owner is purely combinational, with zero added wait states per beat.
- A simultaneous request from all masters in IDLE is resolved strictly by the pointer, with no master starved longer than NUM_MASTERS-1 cycles of ownership.
- Asynchronous reset mid-transfer:
  - All outputs drop to their reset values immediately.
  - The pointer resets.
  - No response is issued to the interrupted master.

## Configuration
- WB_RR_ARB_WATCHDOG_EN defined:
  - A 16-bit counter clears on grant and on any slave ack/err/rty.
  - The counter increments each OWN cycle with wbs_stb_o high and no response.
  - On reaching TIMEOUT, for exactly one cycle the owner's wbm_err_o = 1, timeout_o = 1, and wbs_cyc_o/wbs_stb_o are forced to 0; the state then goes to DRAIN.
  - DRAIN → IDLE when the owner's cyc is low, which may be in the abort cycle itself.
  - A slave ack arriving in the abort cycle is discarded.
- Undefined:
  - No counter exists and the DRAIN state is unreachable.
  - timeout_o is tied to 0.
  - A stalled slave holds the bus indefinitely.

## Test plan
- Reset and single master: assert wb_rst_ni low, then master 1 reads 0x00000010 with ack after 2 cycles.
  - During reset, every output is 0.
  - grant_o = 3'b010 one cycle after cyc.
  - wbm_dat_o slice 1 equals wbs_dat_i; wbm_ack_o = 3'b010 for one cycle.
- Round-robin fairness: masters 0, 1 and 2 hold cyc continuously, each releasing after one acked beat.
  - The grant sequence is 0, 1, 2, 0, 1, 2.
  - There is exactly one idle cycle between owners.
- Burst hold: master 0 runs a 4-beat cti=010/bte=00 burst ending in cti=111 while master 2 requests from beat 1.
  - grant_o stays 3'b001 for all 4 acks.
  - Master 2 is granted 2 cycles after master 0 drops cyc.
- Response isolation: the slave asserts err during master 2's cycle.
  - wbm_err_o = 3'b100 only.
  - ack/rty are 0 on all slices.
- Watchdog (macro defined, TIMEOUT=8): master 0 strobes and the slave never acks.
  - Eight cycles after the grant, wbm_err_o[0] and timeout_o pulse once and wbs_cyc_o = 0.
  - The block stays in DRAIN until master 0's cyc is low, then grants a pending master 1.
- Reset mid-burst: pull wb_rst_ni low during beat 2 of a burst.
  - wbs_cyc_o falls asynchronously.
  - After release, master 0 wins a simultaneous 3-way request.
